data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU's load/store port. It accepts one word request at a time through a valid/ready handshake, inserts a configurable number of wait states, then commits the write or returns read data through a registered response handshake. It sits between the CPU memory stage and byte-addressed data storage, and it is the first step toward variable-latency memory behind the pipeline.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, byte-address bits decoded; storage is 2^ADDRESS_WIDTH bytes
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes)
- WAIT_CYCLES, 2, wait states between accept and response; 0 is legal

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, little-endian lanes
- req_be  in  4  store byte enables; bit i selects bits [8i+7:8i]; ignored for loads
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores
- rsp_err  out  1  misaligned access flag (see Configuration)

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch we/addr/wdata/be. Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - The down-counter loads WAIT_CYCLES-1 on accept and decrements each cycle.
  - At count 0, go to RESP.
- Commit happens on the edge that enters RESP:
  - Store: write lanes where be[i]=1. rsp_rdata<=0.
  - Load: rsp_rdata<=word at addr[ADDRESS_WIDTH-1:2].
  - rsp_err is registered on the same edge.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable.
  - When rsp_ready is high, go to IDLE.
  - rsp_valid never drops without rsp_ready.
- Word index is addr[ADDRESS_WIDTH-1:2]. Without the macro, addr[1:0] is ignored.
- A store with be=4'b0000 completes normally and writes nothing.
- Storage is not cleared by rst. Contents are undefined until written.
- Only one request is outstanding at a time; there is no pipelining across requests.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
- Request accepted at edge N: rsp_valid is high from cycle N+1+WAIT_CYCLES.
- With rsp_ready held high, rsp_valid lasts 1 cycle. The next accept is possible one cycle after the response handshake, so the sustained rate is 1 request per WAIT_CYCLES+2 cycles.
- req_ready is a registered function of state only; there is no combinational path from req_valid.
- rst asserted in any state forces IDLE on that edge.
  - Reset takes precedence over the commit edge: a store reaching commit while rst=1 is not written.
  - The in-flight response is discarded.
- req_valid high while req_ready=0 is ignored. The requester holds its signals until accepted.

## Configuration
- Macro: DATA_MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - Any request with addr[1:0]!=0 completes with rsp_err=1 and rsp_rdata=0.
  - A misaligned store writes nothing.
  - Timing is identical to a normal access.
- Undefined: rsp_err is tied to 0 and addr[1:0] is ignored.

## Structure
- Package data_mem_resp_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t
  - localparam WORD_BYTES=4
  - localparam BYTE_W=8
- Sub-module be_ram holds the byte-lane storage. It has synchronous byte-enable write and a combinational word read, indexed by word address.
- The FSM, counter, request latch and response registers live in the top module.

## Test plan
- Reset: after 1 cycle of rst → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store then load, WAIT_CYCLES=2:
  - Stimulus: store 0xDEADBEEF to 0x10 (be=1111), then load 0x10.
  - Required: each rsp_valid rises 3 cycles after its accept, and the load returns 0xDEADBEEF.
- Byte enables:
  - Stimulus: store 0x11223344 to 0x20 (be=1111), then store 0xAABBCCDD to 0x20 (be=0101), then load 0x20.
  - Required: the load returns 0x11BB33DD.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during a load.
  - Required: rsp_valid and rsp_rdata are stable throughout, and req_ready stays 0 until the cycle after rsp_ready=1.
- Mid-operation reset:
  - Stimulus: assert rst in WAIT during a store of 0x55 to 0x30.
  - Required: next cycle state is IDLE, and a later load of 0x30 does not return 0x00000055.
- WAIT_CYCLES=0 and macro:
  - Required: rsp_valid is high 1 cycle after accept.
  - Required with DATA_MEM_RESPONDER_ALIGN_CHECK_EN: a load of 0x12 gives rsp_err=1 and rsp_rdata=0.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and byte-lane geometry for the data memory responder.
// No logic. The package holds only the FSM state encoding and the lane constants.
package data_mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/data_mem_responder_be_ram.sv
// Byte-lane word storage: synchronous byte-enable write, combinational word read.
// Writes take effect on the clock edge. Reads are available in the same cycle. There is no backpressure.
module be_ram
    import data_mem_resp_pkg::*;
#(
    parameter int WORD_ADDR_W = 6
) (
    input  logic                           clk,
    input  logic                           wrEn,
    input  logic [WORD_ADDR_W-1:0]         wordAddr,
    input  logic [WORD_BYTES*BYTE_W-1:0]   wrData,
    input  logic [WORD_BYTES-1:0]          wrBe,
    output logic [WORD_BYTES*BYTE_W-1:0]   rdData
);

    localparam int WORDS = 1 << WORD_ADDR_W;

    logic [WORD_BYTES-1:0][BYTE_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (wrEn && wrBe[i]) begin
                mem[wordAddr][i] <= wrData[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdData = mem[wordAddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with WAIT_CYCLES wait states; optional DATA_MEM_RESPONDER_ALIGN_CHECK_EN.
// Latency: the response is valid WAIT_CYCLES+1 cycles after the request is accepted.
// Backpressure: the response is held until rsp_ready. req_ready stays low from the accept until the response handshake.
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [WORD_BYTES-1:0]    req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    resp_state_t state, stateNext;
    logic [CNT_W-1:0]         waitCnt;
    logic                     accept, commit;

    logic                     latWe;
    logic [ADDRESS_WIDTH-1:0] latAddr;
    logic [DATA_WIDTH-1:0]    latWdata;
    logic [WORD_BYTES-1:0]    latBe;

    logic                     srcWe;
    logic [ADDRESS_WIDTH-1:0] srcAddr;
    logic [DATA_WIDTH-1:0]    srcWdata;
    logic [WORD_BYTES-1:0]    srcBe;
    logic                     misaligned;
    logic                     ramWrEn;
    logic [DATA_WIDTH-1:0]    ramRdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;

    always_comb begin
        stateNext = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        commit    = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNext = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so the live request feeds the RAM directly.
    assign srcWe    = (state == IDLE) ? req_we    : latWe;
    assign srcAddr  = (state == IDLE) ? req_addr  : latAddr;
    assign srcWdata = (state == IDLE) ? req_wdata : latWdata;
    assign srcBe    = (state == IDLE) ? req_be    : latBe;

    assign misaligned = ALIGN_CHECK && (srcAddr[1:0] != 2'b00);
    assign ramWrEn    = commit && srcWe && !misaligned && !rst;

    be_ram #(
        .WORD_ADDR_W (ADDRESS_WIDTH - 2)
    ) u_ram (
        .clk      (clk),
        .wrEn     (ramWrEn),
        .wordAddr (srcAddr[ADDRESS_WIDTH-1:2]),
        .wrData   (srcWdata),
        .wrBe     (srcBe),
        .rdData   (ramRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                waitCnt <= CNT_LOAD;
            end else if ((state == WAIT) && (waitCnt != '0)) begin
                waitCnt <= waitCnt - 1'b1;
            end
            if (commit) begin
                rsp_rdata <= (srcWe || misaligned) ? '0 : ramRdata;
                rsp_err   <= misaligned;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            latWe    <= req_we;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            latBe    <= req_be;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder (WAIT_CYCLES=2), plus a direct check of a zero-wait instance.
module tb_data_mem_responder;
    import data_mem_resp_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
    logic [7:0]  reqAddr;
    logic [31:0] reqWdata, rspRdata;
    logic [3:0]  reqBe;

    logic        reqValid0, reqReady0, reqWe0, rspValid0, rspReady0, rspErr0;
    logic [7:0]  reqAddr0;
    logic [31:0] reqWdata0, rspRdata0;
    logic [3:0]  reqBe0;

    data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr)
    );

    data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_ready(reqReady0), .req_we(reqWe0),
        .req_addr(reqAddr0), .req_wdata(reqWdata0), .req_be(reqBe0),
        .rsp_valid(rspValid0), .rsp_ready(rspReady0), .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sbQ[$];
    logic prevValid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected response is queued on the negedge before the accept edge.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] expData, input logic expErr,
                         input bit track);
        int n = 0;
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        reqBe    = be;
        while (!reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual=req_ready low required=accept within 50 cycles");
            reqValid = 1'b0;
            return;
        end
        if (track) sbQ.push_back('{expData, expErr, cyc + 1 + W});
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic tx0(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] expData, input logic expErr);
        @(negedge clk);
        reqValid0 = 1'b1;
        reqWe0    = we;
        reqAddr0  = addr;
        reqWdata0 = wdata;
        reqBe0    = be;
        chk("w0_req_ready", 32'(reqReady0), 32'd1);
        @(negedge clk);
        reqValid0 = 1'b0;
        chk("w0_rsp_valid_1cyc", 32'(rspValid0), 32'd1);
        chk("w0_rdata", rspRdata0, expData);
        chk("w0_err", 32'(rspErr0), 32'(expErr));
        @(negedge clk);
        chk("w0_valid_drop", 32'(rspValid0), 32'd0);
        chk("w0_ready_back", 32'(reqReady0), 32'd1);
    endtask

    // Monitor: latency on each rising rsp_valid, data/err on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (rspValid && !prevValid) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: actual=rsp_valid high required=no response pending");
                end else begin
                    chk("rsp_latency", 32'(cyc), 32'(sbQ[0].due));
                end
            end
            if (rspValid && rspReady && sbQ.size() != 0) begin
                exp_t e;
                e = sbQ.pop_front();
                chk("rsp_rdata", rspRdata, e.rdata);
                chk("rsp_err", 32'(rspErr), 32'(e.err));
            end
            prevValid = rspValid;
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = '0; rspReady = 1'b1;
        reqValid0 = 1'b0; reqWe0 = 1'b0; reqAddr0 = '0; reqWdata0 = '0; reqBe0 = '0; rspReady0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(reqReady), 32'd1);
        chk("reset_rsp_valid", 32'(rspValid), 32'd0);
        chk("reset_rsp_rdata", rspRdata, 32'd0);
        chk("reset_rsp_err", 32'(rspErr), 32'd0);
        chk("reset_w0_rsp_valid", 32'(rspValid0), 32'd0);
        rst = 1'b0;

        issue(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 8'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b1, 8'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 8'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b1);
        issue(1'b1, 8'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 8'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
        issue(1'b0, 8'h12, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 8'h22, 32'h99999999, 4'b1111, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 8'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b1);
`else
        issue(1'b0, 8'h12, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b1, 8'h22, 32'h99999999, 4'b1111, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 8'h20, 32'h0, 4'b0000, 32'h99999999, 1'b0, 1'b1);
`endif
        waitDrain();

        // Backpressure: response held for 5 cycles with rsp_ready low.
        rspReady = 1'b0;
        issue(1'b0, 8'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        n = 0;
        while (!rspValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rspValid), 32'd1);
            chk("bp_rsp_rdata", rspRdata, 32'hDEADBEEF);
            chk("bp_req_ready", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rspReady = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_handshake", 32'(reqReady), 32'd0);
        @(negedge clk);
        chk("bp_req_ready_after", 32'(reqReady), 32'd1);
        chk("bp_rsp_valid_after", 32'(rspValid), 32'd0);
        waitDrain();

        // Reset coinciding with the commit edge of a store must drop the write.
        issue(1'b1, 8'h30, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b1);
        waitDrain();
        issue(1'b1, 8'h30, 32'h00000055, 4'b1111, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        chk("midrst_req_ready", 32'(reqReady), 32'd1);
        chk("midrst_rsp_valid", 32'(rspValid), 32'd0);
        rst = 1'b0;
        issue(1'b0, 8'h30, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1'b1);
        waitDrain();

        tx0(1'b1, 8'h04, 32'h12345678, 4'b1111, 32'h0, 1'b0);
        tx0(1'b0, 8'h04, 32'h0, 4'b0000, 32'h12345678, 1'b0);
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
        tx0(1'b0, 8'h06, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
        tx0(1'b0, 8'h06, 32'h0, 4'b0000, 32'h12345678, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
